// File: rtl/operand2_shift_pipe_pkg.sv
// Shared types for the ARM operand-2 pipeline: shift types, operand modes
// and the control word carried from the decode stage to the shift stage.
package arm_shift_pkg;

    // Encoding matches instruction bits [6:5].
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        MD_MEM = 2'b00,  // 12-bit load/store offset, passed through
        MD_IMM = 2'b01,  // rotated 8-bit immediate
        MD_REG = 2'b10,  // shift amount from Rs[7:0]
        MD_ISH = 2'b11   // shift amount from instruction bits [11:7]
    } mode_t;

    localparam int OP_W = 12;

    // Decode-stage control word. Rm and the saturated amount are held
    // beside it because their widths follow DATA_W.
    typedef struct packed {
        mode_t           mode;
        shift_t          sh_type;
        logic            zero_amt;  // result is Rm (or the raw immediate), carry is c_in
        logic            over;      // amount strictly above DATA_W
        logic            exact;     // amount equal to DATA_W
        logic            rrx;       // ROR #0 in immediate-shift form
        logic            c_in;
        logic [OP_W-1:0] payload;   // imm8 in [7:0], or the full offset
    } s1_ctl_t;

endpackage

// File: rtl/operand2_shift_pipe_if.sv
// Operand/result bundle between operand fetch, the operand-2 pipe and the ALU.
// Handshake: a beat moves on in_valid & in_ready and a result moves on
// out_valid & out_ready; a producer holding valid keeps its payload stable
// until the matching ready is seen.
interface operand2_shift_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] val_rm;
    logic [DATA_W-1:0] val_rs;
    logic [11:0]       shift_operand;
    logic              imm;
    logic              mem_off;
    logic              c_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] val2;
    logic              c_out;

    modport master (
        output in_valid, val_rm, val_rs, shift_operand, imm, mem_off, c_in, out_ready,
        input  in_ready, out_valid, val2, c_out
    );

    modport slave (
        input  in_valid, val_rm, val_rs, shift_operand, imm, mem_off, c_in, out_ready,
        output in_ready, out_valid, val2, c_out
    );
endinterface

// File: rtl/operand2_shift_pipe_core.sv
// Combinational barrel shifter. A zero amount returns the data unchanged with
// fill_c as carry, except ROR where it performs RRX. Saturated amounts are
// handled by the caller.
module barrel_shift_core
    import arm_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int AMT_W = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  shift_t            sh_type,
    input  logic [AMT_W-1:0]  amt,
    input  logic              fill_c,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [AMT_W-1:0] amt_m1;
    logic [AMT_W-1:0] neg_amt;

    // Carry taps: last bit shifted out is data[amt-1] going right, data[DATA_W-amt] going left.
    always_comb begin
        amt_m1  = amt - AMT_W'(1);
        neg_amt = AMT_W'(0) - amt;
        result  = data;
        carry   = fill_c;
        case (sh_type)
            SH_LSL: begin
                result = data << amt;
                if (amt != '0) carry = data[neg_amt];
            end
            SH_LSR: begin
                result = data >> amt;
                if (amt != '0) carry = data[amt_m1];
            end
            SH_ASR: begin
                result = $unsigned($signed(data) >>> amt);
                if (amt != '0) carry = data[amt_m1];
            end
            SH_ROR: begin
                if (amt == '0) begin
                    result = {fill_c, data[DATA_W-1:1]};
                    carry  = data[0];
                end else begin
                    result = (data >> amt) | (data << neg_amt);
                    carry  = data[amt_m1];
                end
            end
            default: begin
                result = data;
                carry  = fill_c;
            end
        endcase
    end

endmodule

// File: rtl/operand2_shift_pipe.sv
// ARM operand-2 generator: S1 decodes mode and amount, S2 shifts and selects
// the carry. Two registered stages with a valid/ready handshake.
// Shift amounts are decoded through a 16-bit intermediate, so DATA_W up to 2^15.
module operand2_shift_pipe
    import arm_shift_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    operand2_shift_pipe_if.slave bus
);

    localparam int               AMT_W    = $clog2(DATA_W);
    localparam logic [AMT_W:0]   AMT_SAT  = (AMT_W+1)'(DATA_W);
    localparam logic [15:0]      DATA_W_N = 16'(DATA_W);

    logic              s1_valid_q, s2_valid_q;
    logic              s1_adv, in_ready;
    s1_ctl_t           s1_ctl_q, s1_ctl_d;
    logic [AMT_W:0]    s1_amt_q, s1_amt_d;
    logic [DATA_W-1:0] s1_rm_q;
    logic [DATA_W-1:0] val2_q, val2_d;
    logic              c_out_q, c_out_d;

    shift_t            sh_w;
    logic [15:0]       n_w;
    logic [15:0]       rot_w;

    logic [DATA_W-1:0] core_data, core_res;
    shift_t            core_type;
    logic              core_carry;
    logic              unused_bits;

    // S1 moves when S2 is free or draining; in_ready never looks at in_valid.
    assign s1_adv   = !s2_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.val2      = val2_q;
    assign bus.c_out     = c_out_q;

    assign unused_bits = ^{bus.val_rs[DATA_W-1:8], rot_w[15:AMT_W], s1_amt_q[AMT_W]};

    // Decode: pick the mode, saturate the amount and flag the special cases.
    always_comb begin
        s1_ctl_d         = '0;
        s1_amt_d         = '0;
        n_w              = '0;
        rot_w            = '0;
        sh_w             = shift_t'(bus.shift_operand[6:5]);
        s1_ctl_d.sh_type = sh_w;
        s1_ctl_d.c_in    = bus.c_in;
        s1_ctl_d.payload = bus.shift_operand;
        if (bus.mem_off) begin
            s1_ctl_d.mode = MD_MEM;
        end else if (bus.imm) begin
            s1_ctl_d.mode     = MD_IMM;
            rot_w             = {11'b0, bus.shift_operand[11:8], 1'b0};
            s1_amt_d          = {1'b0, rot_w[AMT_W-1:0]};
            s1_ctl_d.zero_amt = (bus.shift_operand[11:8] == 4'd0);
        end else begin
            if (bus.shift_operand[4]) begin
                s1_ctl_d.mode = MD_REG;
                n_w           = {8'b0, bus.val_rs[7:0]};
            end else begin
                s1_ctl_d.mode = MD_ISH;
                n_w           = {11'b0, bus.shift_operand[11:7]};
            end
            if (n_w == '0) begin
                if (bus.shift_operand[4]) begin
                    s1_ctl_d.zero_amt = 1'b1;
                end else begin
                    // Immediate #0 encodes LSL #0, LSR/ASR #DATA_W and RRX.
                    case (sh_w)
                        SH_LSL: s1_ctl_d.zero_amt = 1'b1;
                        SH_LSR, SH_ASR: begin
                            s1_ctl_d.exact = 1'b1;
                            s1_amt_d       = AMT_SAT;
                        end
                        SH_ROR: s1_ctl_d.rrx = 1'b1;
                        default: s1_ctl_d.zero_amt = 1'b1;
                    endcase
                end
            end else if (sh_w == SH_ROR) begin
                s1_amt_d = {1'b0, n_w[AMT_W-1:0]};
            end else if (n_w >= DATA_W_N) begin
                s1_amt_d       = AMT_SAT;
                s1_ctl_d.exact = (n_w == DATA_W_N);
                s1_ctl_d.over  = (n_w != DATA_W_N);
            end else begin
                s1_amt_d = n_w[AMT_W:0];
            end
        end
    end

    // Shifter operand: immediates rotate the zero-extended imm8, shifts use Rm.
    always_comb begin
        core_data = s1_rm_q;
        core_type = s1_ctl_q.sh_type;
        case (s1_ctl_q.mode)
            MD_MEM: core_data = DATA_W'(s1_ctl_q.payload);
            MD_IMM: begin
                core_data = DATA_W'(s1_ctl_q.payload[7:0]);
                core_type = SH_ROR;
            end
            default: core_data = s1_rm_q;
        endcase
    end

    barrel_shift_core #(.DATA_W(DATA_W)) u_core (
        .data    (core_data),
        .sh_type (core_type),
        .amt     (s1_amt_q[AMT_W-1:0]),
        .fill_c  (s1_ctl_q.c_in),
        .result  (core_res),
        .carry   (core_carry)
    );

    // S2 result: raw shifter output with the zero/saturation overrides applied.
    always_comb begin
        val2_d  = core_res;
        c_out_d = core_carry;
        case (s1_ctl_q.mode)
            MD_MEM: begin
                val2_d  = core_data;
                c_out_d = s1_ctl_q.c_in;
            end
            MD_IMM: begin
                if (s1_ctl_q.zero_amt) begin
                    val2_d  = core_data;
                    c_out_d = s1_ctl_q.c_in;
                end else begin
                    c_out_d = core_res[DATA_W-1];
                end
            end
            default: begin
                if (s1_ctl_q.zero_amt) begin
                    val2_d  = s1_rm_q;
                    c_out_d = s1_ctl_q.c_in;
                end else if (!s1_ctl_q.rrx) begin
                    case (s1_ctl_q.sh_type)
                        SH_LSL: begin
                            if (s1_ctl_q.exact) begin
                                val2_d  = '0;
                                c_out_d = s1_rm_q[0];
                            end else if (s1_ctl_q.over) begin
                                val2_d  = '0;
                                c_out_d = 1'b0;
                            end
                        end
                        SH_LSR: begin
                            if (s1_ctl_q.exact) begin
                                val2_d  = '0;
                                c_out_d = s1_rm_q[DATA_W-1];
                            end else if (s1_ctl_q.over) begin
                                val2_d  = '0;
                                c_out_d = 1'b0;
                            end
                        end
                        SH_ASR: begin
                            if (s1_ctl_q.exact || s1_ctl_q.over) begin
                                val2_d  = {DATA_W{s1_rm_q[DATA_W-1]}};
                                c_out_d = s1_rm_q[DATA_W-1];
                            end
                        end
                        SH_ROR: begin
                            // Non-zero multiple of DATA_W: value unchanged, carry is the MSB.
                            if (s1_amt_q[AMT_W-1:0] == '0) begin
                                val2_d  = s1_rm_q;
                                c_out_d = s1_rm_q[DATA_W-1];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Stage valids: reset and flush kill both; otherwise advance with the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (in_ready) s1_valid_q <= bus.in_valid;
            if (s1_adv)   s2_valid_q <= s1_valid_q;
        end
    end

    // S1 payload registers load on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ctl_q <= '0;
            s1_amt_q <= '0;
            s1_rm_q  <= '0;
        end else if (bus.in_valid && in_ready) begin
            s1_ctl_q <= s1_ctl_d;
            s1_amt_q <= s1_amt_d;
            s1_rm_q  <= bus.val_rm;
        end
    end

    // S2 result registers load only when a valid S1 beat advances, so a stalled result holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            val2_q  <= '0;
            c_out_q <= 1'b0;
        end else if (s1_valid_q && s1_adv) begin
            val2_q  <= val2_d;
            c_out_q <= c_out_d;
        end
    end

endmodule

// File: tb/tb_operand2_shift_pipe.sv
// Directed bench for operand2_shift_pipe with DATA_W = 32.
module tb_operand2_shift_pipe;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  logic [32:0] exp_q[$];

  operand2_shift_pipe_if #(.DATA_W(32)) bus ();

  operand2_shift_pipe #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  // compare and count
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] so,
                       input logic im, input logic mo, input logic ci);
    bus.val_rm        = rm;
    bus.val_rs        = rs;
    bus.shift_operand = so;
    bus.imm           = im;
    bus.mem_off       = mo;
    bus.c_in          = ci;
  endtask

  task automatic single(input string tag, input logic [31:0] rm, input logic [31:0] rs,
                        input logic [11:0] so, input logic im, input logic mo, input logic ci,
                        input logic [31:0] ev, input logic ec);
    @(negedge clk);
    drive(rm, rs, so, im, mo, ci);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_val2"}, bus.val2, ev);
    chk({tag, "_cout"}, 32'(bus.c_out), 32'(ec));
  endtask

  task automatic fill_two();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(32'h1234_5678, 32'h0, 12'h000, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(32'h0BAD_F00D, 32'h0, 12'h000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    chk("full_val2", bus.val2, 32'h1234_5678);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic idle_none(input string tag, input int n);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, 32'(bus.out_valid), 32'd0);
    end
  endtask

  // stream table
  logic [31:0] st_rm [5] = '{32'h8000_0003, 32'h0, 32'h0, 32'h0000_00F8, 32'h8000_0000};
  logic [31:0] st_rs [5] = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd0};
  logic [11:0] st_so [5] = '{12'h080, 12'h1FF, 12'h123, 12'h030, 12'h240};
  logic        st_im [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        st_mo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [32:0] st_ex [5] = '{{1'b1, 32'h0000_0006}, {1'b1, 32'hC000_003F},
                             {1'b0, 32'h0000_0123}, {1'b1, 32'h0000_000F},
                             {1'b0, 32'hF800_0000}};

  initial begin
    logic [31:0] prev_v;
    logic        prev_c;
    logic        held;
    logic [32:0] e;
    int          idx;
    int          got;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(32'h0, 32'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_val2", bus.val2, 32'h0);
    chk("rst_cout", 32'(bus.c_out), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // directed single beats
    single("imm_4ff",     32'h0,          32'h0,   12'h4FF, 1, 0, 0, 32'hFF00_0000, 1);
    single("imm_rot0",    32'h0,          32'h0,   12'h0AB, 1, 0, 1, 32'h0000_00AB, 1);
    single("ish_lsr0",    32'h8000_0001,  32'h0,   12'h020, 0, 0, 0, 32'h0,         1);
    single("ish_asr0",    32'h8000_0000,  32'h0,   12'h040, 0, 0, 0, 32'hFFFF_FFFF, 1);
    single("ish_rrx",     32'h3,          32'h0,   12'h060, 0, 0, 1, 32'h8000_0001, 1);
    single("ish_lsl0",    32'h1234_5678,  32'h0,   12'h000, 0, 0, 1, 32'h1234_5678, 1);
    single("ish_lsl4",    32'hF000_0001,  32'h0,   12'h200, 0, 0, 0, 32'h0000_0010, 1);
    single("ish_ror8",    32'h0000_00AB,  32'h0,   12'h460, 0, 0, 0, 32'hAB00_0000, 1);
    single("reg_lsl32",   32'h1,          32'd32,  12'h010, 0, 0, 0, 32'h0,         1);
    single("reg_lsl33",   32'h1,          32'd33,  12'h010, 0, 0, 1, 32'h0,         0);
    single("reg_lsl_rs0", 32'hDEAD_BEEF,  32'd0,   12'h010, 0, 0, 1, 32'hDEAD_BEEF, 1);
    single("reg_rs_hi",   32'h5,          32'h100, 12'h010, 0, 0, 1, 32'h5,         1);
    single("reg_lsr8",    32'h0000_0180,  32'd8,   12'h030, 0, 0, 0, 32'h1,         1);
    single("reg_lsr32",   32'h8000_0000,  32'd32,  12'h030, 0, 0, 0, 32'h0,         1);
    single("reg_lsr200",  32'h8000_0000,  32'd200, 12'h030, 0, 0, 1, 32'h0,         0);
    single("reg_asr40",   32'h7FFF_FFFF,  32'd40,  12'h050, 0, 0, 1, 32'h0,         0);
    single("reg_ror4",    32'h0000_000F,  32'd4,   12'h070, 0, 0, 0, 32'hF000_0000, 1);
    single("reg_ror64",   32'h8000_0000,  32'd64,  12'h070, 0, 0, 0, 32'h8000_0000, 1);
    single("mem_c1",      32'hFFFF_FFFF,  32'h0,   12'hABC, 1, 1, 1, 32'h0000_0ABC, 1);
    single("mem_c0",      32'hFFFF_FFFF,  32'h0,   12'hABC, 1, 1, 0, 32'h0000_0ABC, 0);

    // stream with a mid-stream stall
    idx = 0;
    got = 0;
    held = 1'b0;
    prev_v = '0;
    prev_c = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc < 7);
      if (idx < 5) begin
        drive(st_rm[idx], st_rs[idx], st_so[idx], st_im[idx], st_mo[idx], 1'b0);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) chk("stream_in_ready_pre", 32'(bus.in_ready), 32'd1);
      if (cyc >= 3 && cyc < 7) chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid) begin
        if (held) begin
          chk("stall_val2", bus.val2, prev_v);
          chk("stall_cout", 32'(bus.c_out), 32'(prev_c));
        end
        if (bus.out_ready) begin
          chk("stream_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stream_val2", bus.val2, e[31:0]);
            chk("stream_cout", 32'(bus.c_out), 32'(e[32]));
          end
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev_v = bus.val2;
          prev_c = bus.c_out;
        end
      end else begin
        held = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(st_ex[idx]);
        idx++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'd5);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // flush with both stages full
    fill_two();
    drive(32'hCAFE_0001, 32'h0, 12'h000, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    idle_none("flush_no_ghost", 4);

    // beat offered in the flush cycle into an empty pipe
    @(negedge clk);
    drive(32'hCAFE_0002, 32'h0, 12'h000, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    idle_none("flush_same_cycle", 3);

    // reset with both stages full
    fill_two();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_val2", bus.val2, 32'h0);
    chk("mid_rst_cout", 32'(bus.c_out), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    idle_none("rst_no_ghost", 3);

    single("after_rst", 32'h0000_00F0, 32'd4, 12'h030, 0, 0, 0, 32'h0000_000F, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand2_shift_pipe.md
# operand2_shift_pipe

Pipelined, parametrised ARM operand-2 generator for the EXE stage. It produces the second ALU operand (`val2`) together with the shifter carry-out (`c_out`). It supports:
- rotated 8-bit immediates
- immediate-amount shifts
- register-amount shifts taken from Rs
- RRX
- the 12-bit memory-offset pass-through

The block is two registered stages with a valid/ready handshake. It sits between ID/EXE operand fetch and the ALU, and its `c_out` feeds the ALU's logical-op C flag.

## Interface
- `DATA_W`, 32: operand width; a power of two ≥ 16. `AMT_W = $clog2(DATA_W)`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous kill of both stages (branch taken); has priority below `rst`
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat this cycle
- `val_rm`  in  DATA_W  Rm value
- `val_rs`  in  DATA_W  Rs value; only bits [7:0] are used
- `shift_operand`  in  12  instruction bits [11:0]
- `imm`  in  1  I bit: rotated-immediate form
- `mem_off`  in  1  load/store: `val2 = zero-extended shift_operand`
- `c_in`  in  1  current CPSR C
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `val2`  out  DATA_W  operand 2
- `c_out`  out  1  shifter carry-out

## Operation
Mode priority: `mem_off` > `imm` > register shift (`shift_operand[4]=1`) > immediate shift.

- **mem_off:** `val2 = {0, shift_operand}`; `c_out = c_in`.
- **imm:** `val2 = ROR(zext(imm8), 2*rot4)`, where `imm8 = shift_operand[7:0]` and `rot4 = shift_operand[11:8]`. `c_out = c_in` if `rot4 == 0`, else `val2[DATA_W-1]`.
- **Immediate shift:** type = `[6:5]` (00 LSL, 01 LSR, 10 ASR, 11 ROR); `n = [11:7]`. A zero amount is special-cased:
  - LSL #0: `val2 = Rm`, `c_out = c_in`
  - LSR #0: treated as LSR #DATA_W
  - ASR #0: treated as ASR #DATA_W
  - ROR #0: RRX, `val2 = {c_in, Rm[DATA_W-1:1]}`, `c_out = Rm[0]`
- **Register shift:** `n = val_rs[7:0]` (0..255).
  - `n == 0`: `val2 = Rm`, `c_out = c_in`, for all types.
  - LSL, `n < DATA_W`: `c_out = Rm[DATA_W-n]`.
  - LSL, `n == DATA_W`: `val2 = 0`, `c_out = Rm[0]`.
  - LSL, `n > DATA_W`: `val2 = 0`, `c_out = 0`.
  - LSR, `n < DATA_W`: `c_out = Rm[n-1]`.
  - LSR, `n == DATA_W`: `val2 = 0`, `c_out = Rm[DATA_W-1]`.
  - LSR, `n > DATA_W`: `val2 = 0`, `c_out = 0`.
  - ASR, `n ≥ DATA_W`: `val2` all sign bits; `c_out = Rm[DATA_W-1]`.
  - ROR, `n[AMT_W-1:0] == 0` with `n != 0`: `val2 = Rm`, `c_out = Rm[DATA_W-1]`.
  - ROR otherwise: rotate by `n mod DATA_W`; `c_out = Rm[(n mod DATA_W)-1]`.
- **Non-zero immediate-shift amounts:** same rules as register shift for `0 < n < DATA_W`.
- **Stage S1 (decode):** registers mode, type, saturated amount (`AMT_W+1` bits), the special-case flags (`zero_amt`, `over`, `exact`, `rrx`), `Rm`, `c_in` and the imm8/offset payload.
- **Stage S2 (shift):** performs the barrel shift and carry select, then registers `val2` and `c_out`.
- **Handshake:**
  - A beat transfers on `in_valid & in_ready`; the result is consumed on `out_valid & out_ready`.
  - `in_ready = !s1_valid | s1_adv`.
  - `s1_adv = !s2_valid | out_ready`.
  - Holding `out_ready` low freezes both stages once both are full; no beat is dropped or duplicated.
  - While `out_valid` is high and `out_ready` is low, `val2`/`c_out` must not change.

## Timing
- **Latency:** 2 cycles from accepted input to `out_valid`. Throughput is 1 beat per cycle when `out_ready` is held high.
- **Reset:** `out_valid = 0`, `val2 = 0`, `c_out = 0`, internal valids = 0. `in_ready = 1` the cycle after reset releases.
- **flush:** clears `s1_valid`/`s2_valid` at the next edge. A beat presented in the same cycle as `flush` is discarded. Data registers may hold stale values, but `out_valid` must be 0.
- **Simultaneous input and output transfer** with both stages full: both happen, and occupancy stays at 2.
- **`rst` mid-operation:** behaves as reset regardless of handshake state.
- **No combinational path** from `in_*` to `out_*`. `in_ready` depends only on registered state and `out_ready`.

## Structure
- **Package `arm_shift_pkg`:**
  - shift-type enum: `SH_LSL`, `SH_LSR`, `SH_ASR`, `SH_ROR`
  - mode enum: `MD_MEM`, `MD_IMM`, `MD_REG`, `MD_ISH`
  - S1→S2 payload struct typedef
- **Sub-module `barrel_shift_core`:** parametrised by `DATA_W`; purely combinational. Takes `data`, `type`, `amt[AMT_W-1:0]` and `fill_c` (for RRX), and returns the shifted value plus a raw carry bit. S2 applies the saturation overrides around it.

## Test plan
- `imm=1`, `shift_operand=12'h4FF` → `val2=32'hFF00_0000`, `c_out=1`, two cycles after acceptance.
- Immediate LSR #0 with `Rm=32'h8000_0001` → `val2=0`, `c_out=1`. ROR #0 (RRX) with `Rm=3`, `c_in=1` → `val2=32'h8000_0001`, `c_out=1`.
- Register LSL with `Rm=1`: `Rs=32` → `val2=0`, `c_out=1`; `Rs=33` → `val2=0`, `c_out=0`. Register ROR with `Rs=64`, `Rm=32'h8000_0000` → `val2` unchanged, `c_out=1`.
- `mem_off=1`, `shift_operand=12'hABC` with `imm=1` also set → `val2=32'h0000_0ABC`, `c_out=c_in`.
- Stream 5 beats back-to-back while holding `out_ready=0` for 4 cycles mid-stream → `in_ready` drops after 2 beats are held; all 5 results emerge in order and stay stable while stalled.
- Assert `flush`, then separately `rst`, with both stages full → the next cycle has `out_valid=0` and no flushed beat ever appears; after reset, `val2=0` and `c_out=0`.
